// File: rtl/uart_rx.sv
// +----------------------------------------------------------------------------+
// | uart_rx : 8N1 serial receiver with mid-bit sampling and framing detection. |
// | Optional even/odd parity bit when UART_RX_PARITY_EN is defined.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int CNT_W    = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  input  logic       i_rx,
  input  logic [2:0] i_rx_uart_bps,
  output logic [7:0] o_data,
  output logic       o_flag,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP  = 3'd4,
    S_BRK   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic             rx_fall;
  logic             mid;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`endif

  function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] bps);
    case (bps)
      3'd0:    baud_div = CNT_W'(CLK_FREQ / 1200);
      3'd1:    baud_div = CNT_W'(CLK_FREQ / 4800);
      3'd2:    baud_div = CNT_W'(CLK_FREQ / 9600);
      3'd3:    baud_div = CNT_W'(CLK_FREQ / 19200);
      3'd4:    baud_div = CNT_W'(CLK_FREQ / 38400);
      3'd5:    baud_div = CNT_W'(CLK_FREQ / 57600);
      3'd6:    baud_div = CNT_W'(CLK_FREQ / 115200);
      default: baud_div = CNT_W'(CLK_FREQ / 230400);
    endcase
  endfunction

  // Idle-high line: synchronizer and edge flop reset to 1 so reset never looks like a start edge.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_fall = rx_d & ~rx_s;
  assign mid     = (cnt == (div >> 1));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      div         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      o_data      <= 8'h00;
      o_flag      <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
      par_bad      <= 1'b0;
`endif
    end else begin
      o_flag      <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      if (state != S_IDLE)
        cnt <= (cnt == div - 1'b1) ? '0 : cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (rx_fall) begin
            cnt   <= '0;
            div   <= baud_div(i_rx_uart_bps);
            state <= S_START;
          end
        end
        S_START: begin
          if (mid) begin
            if (!rx_s) begin
              o_busy  <= 1'b1;
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (mid) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (mid) begin
            par_bad <= rx_s ^ (^shreg) ^ PARITY_ODD;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
          if (mid) begin
            o_data      <= shreg;
            o_busy      <= 1'b0;
            o_flag      <= rx_s;
            o_frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= par_bad;
`endif
            state <= rx_s ? S_IDLE : S_BRK;
          end
        end
        S_BRK: begin
          if (rx_s)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx : directed vector bench for uart_rx (scaled clock frequency).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

  // 2.304 MHz keeps every divisor exact: bps2 -> 240, bps6 -> 20, bps7 -> 10.
  localparam int TB_CLK = 2_304_000;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  typedef struct {
    logic [2:0] bps;
    logic [2:0] bps_mid;
    logic [7:0] data;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [2:0] bps;
  logic [7:0] data;
  logic       flag;
  logic       ferr;
  logic       perr;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         flag_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         busy_cyc = 0;
  int         viol = 0;
  int         last_flag_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] data_q[$];

  uart_rx #(.CLK_FREQ(TB_CLK), .CNT_W(16)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_rx         (rx),
    .i_rx_uart_bps(bps),
    .o_data       (data),
    .o_flag       (flag),
    .o_frame_err  (ferr),
    .o_parity_err (perr),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (flag) begin
      flag_cnt      = flag_cnt + 1;
      last_data     = data;
      last_flag_cyc = cyc;
      data_q.push_back(data);
    end
    if (ferr) begin
      ferr_cnt  = ferr_cnt + 1;
      last_data = data;
    end
    if (perr) perr_cnt = perr_cnt + 1;
    if (busy) busy_cyc = busy_cyc + 1;
    if (flag && ferr) viol = viol + 1;
    if ((flag || ferr) && busy) viol = viol + 1;
    if (perr && !(flag || ferr)) viol = viol + 1;
  end

  function automatic int div_of(input logic [2:0] b);
    case (b)
      3'd0:    return TB_CLK / 1200;
      3'd1:    return TB_CLK / 4800;
      3'd2:    return TB_CLK / 9600;
      3'd3:    return TB_CLK / 19200;
      3'd4:    return TB_CLK / 38400;
      3'd5:    return TB_CLK / 57600;
      3'd6:    return TB_CLK / 115200;
      default: return TB_CLK / 230400;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] b, input logic [2:0] b_mid, input logic [7:0] d,
                            input logic stop, input logic par_flip);
    int dv;
    dv  = div_of(b);
    bps = b;
    rx  = 1'b0;
    wait_cyc(dv);
    bps = b_mid;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(dv);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_cyc(dv);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop;
    wait_cyc(dv);
  endtask

  vec_t vecs[8];
  int   f0, e0, p0, b0, t0, q0, dv, lat;

  initial begin
    vecs[0] = '{bps: 3'd2, bps_mid: 3'd2, data: 8'h55, exp_data: 8'h55};
    vecs[1] = '{bps: 3'd6, bps_mid: 3'd6, data: 8'hA3, exp_data: 8'hA3};
    vecs[2] = '{bps: 3'd7, bps_mid: 3'd7, data: 8'h3C, exp_data: 8'h3C};
    vecs[3] = '{bps: 3'd3, bps_mid: 3'd3, data: 8'h81, exp_data: 8'h81};
    vecs[4] = '{bps: 3'd1, bps_mid: 3'd1, data: 8'h0F, exp_data: 8'h0F};
    vecs[5] = '{bps: 3'd0, bps_mid: 3'd0, data: 8'hC6, exp_data: 8'hC6};
    vecs[6] = '{bps: 3'd4, bps_mid: 3'd7, data: 8'hFF, exp_data: 8'hFF};
    vecs[7] = '{bps: 3'd2, bps_mid: 3'd6, data: 8'h00, exp_data: 8'h00};

    rst_n = 1'b0;
    rx    = 1'b1;
    bps   = 3'd2;
    wait_cyc(3);
    check("reset_data", data, 8'h00);
    check("reset_flag", flag, 1'b0);
    check("reset_frame_err", ferr, 1'b0);
    check("reset_parity_err", perr, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Good frames across baud rates, including a bps change mid-frame.
    for (int i = 0; i < 8; i++) begin
      f0 = flag_cnt; e0 = ferr_cnt; b0 = busy_cyc; t0 = cyc;
      dv = div_of(vecs[i].bps);
      send_frame(vecs[i].bps, vecs[i].bps_mid, vecs[i].data, 1'b1, 1'b0);
      wait_cyc(2 * dv);
      lat = last_flag_cyc - t0;
      check($sformatf("vec%0d_flag_count", i), flag_cnt - f0, 1);
      check($sformatf("vec%0d_frame_err_count", i), ferr_cnt - e0, 0);
      check($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy_cycles", i), busy_cyc - b0, (NBITS + 1) * dv);
      check($sformatf("vec%0d_latency_window", i),
            (lat >= (NBITS + 1) * dv + dv / 2 + 2) && (lat <= (NBITS + 1) * dv + dv / 2 + 5), 1);
    end

    // Back-to-back frames 0..7, no idle gap between stop and next start.
    f0 = flag_cnt; e0 = ferr_cnt; q0 = data_q.size();
    for (int i = 0; i < 8; i++) send_frame(3'd2, 3'd2, 8'(i), 1'b1, 1'b0);
    wait_cyc(2 * div_of(3'd2));
    check("b2b_flag_count", flag_cnt - f0, 8);
    check("b2b_frame_err_count", ferr_cnt - e0, 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("b2b_data%0d", i), (data_q.size() > q0 + i) ? data_q[q0 + i] : 8'hXX, 8'(i));

    // Glitch shorter than half a bit must be rejected silently.
    f0 = flag_cnt; e0 = ferr_cnt; b0 = busy_cyc;
    rx = 1'b0;
    wait_cyc(46);
    rx = 1'b1;
    wait_cyc(2 * div_of(3'd2));
    check("glitch_flag_count", flag_cnt - f0, 0);
    check("glitch_frame_err_count", ferr_cnt - e0, 0);
    check("glitch_busy_cycles", busy_cyc - b0, 0);
    f0 = flag_cnt;
    send_frame(3'd2, 3'd2, 8'hA3, 1'b1, 1'b0);
    wait_cyc(div_of(3'd2));
    check("post_glitch_flag_count", flag_cnt - f0, 1);
    check("post_glitch_data", last_data, 8'hA3);

    // Framing error with the line held low (break) for three more bit times.
    f0 = flag_cnt; e0 = ferr_cnt;
    send_frame(3'd2, 3'd2, 8'h3C, 1'b0, 1'b0);
    wait_cyc(3 * div_of(3'd2));
    check("break_frame_err_count", ferr_cnt - e0, 1);
    check("break_flag_count", flag_cnt - f0, 0);
    check("break_data", last_data, 8'h3C);
    rx = 1'b1;
    wait_cyc(2 * div_of(3'd2));
    check("break_release_flag_count", flag_cnt - f0, 0);
    send_frame(3'd2, 3'd2, 8'h3C, 1'b1, 1'b0);
    wait_cyc(div_of(3'd2));
    check("after_break_flag_count", flag_cnt - f0, 1);
    check("after_break_frame_err_count", ferr_cnt - e0, 1);
    check("after_break_data", last_data, 8'h3C);

    // Asynchronous reset in the middle of the data bits.
    f0 = flag_cnt; e0 = ferr_cnt;
    bps = 3'd2;
    rx  = 1'b0; wait_cyc(div_of(3'd2));
    rx  = 1'b1; wait_cyc(div_of(3'd2));
    rx  = 1'b0; wait_cyc(div_of(3'd2) / 2);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midreset_data", data, 8'h00);
    check("midreset_busy", busy, 1'b0);
    rx    = 1'b1;
    rst_n = 1'b1;
    wait_cyc(12 * div_of(3'd2));
    check("midreset_flag_count", flag_cnt - f0, 0);
    check("midreset_frame_err_count", ferr_cnt - e0, 0);
    send_frame(3'd2, 3'd2, 8'h81, 1'b1, 1'b0);
    wait_cyc(div_of(3'd2));
    check("post_reset_flag_count", flag_cnt - f0, 1);
    check("post_reset_data", last_data, 8'h81);

`ifdef UART_RX_PARITY_EN
    f0 = flag_cnt; p0 = perr_cnt;
    send_frame(3'd6, 3'd6, 8'h07, 1'b1, 1'b1);
    wait_cyc(2 * div_of(3'd6));
    check("parity_bad_flag_count", flag_cnt - f0, 1);
    check("parity_bad_perr_count", perr_cnt - p0, 1);
    check("parity_bad_data", last_data, 8'h07);
`else
    p0 = 0;
    check("parity_err_never", perr_cnt - p0, 0);
`endif

    check("strobe_overlap_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
